// File: rtl/jpeg_pkg.sv
// Shared JPEG types and constants for the Y/Cb/Cr zig-zag serializers:
// coefficient type, drain state encoding and the standard zig-zag scan tables.
package jpeg_pkg;

  localparam int COEF_W_DEFAULT = 11;

  typedef logic signed [COEF_W_DEFAULT-1:0] coef_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;

  // Row/column of each zig-zag position, index 0 being the DC term
  localparam logic [2:0] ZZ_ROW [64] = '{
    3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3,
    3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
    3'd5, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd1,
    3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4,
    3'd3, 3'd2, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7,
    3'd6, 3'd5, 3'd4, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6,
    3'd5, 3'd6, 3'd7, 3'd7
  };

  localparam logic [2:0] ZZ_COL [64] = '{
    3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0,
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1,
    3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd6,
    3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4,
    3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd3,
    3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd6, 3'd5, 3'd4, 3'd5, 3'd6,
    3'd7, 3'd7, 3'd6, 3'd7
  };

endpackage

// File: rtl/zigzag_index_rom.sv
// Combinational zig-zag lookup: 6-bit scan index to 3-bit row and column.
module zigzag_index_rom
  import jpeg_pkg::*;
(
  input  logic [5:0] idx,
  output logic [2:0] row,
  output logic [2:0] col
);

  assign row = ZZ_ROW[idx];
  assign col = ZZ_COL[idx];

endmodule

// File: rtl/cb_zigzag_serializer.sv
// Double-buffered Cb block serializer: captures whole 8x8 blocks on a strobe
// and streams them out in zig-zag order over a valid/ready interface.
module cb_zigzag_serializer
  import jpeg_pkg::*;
#(
  parameter int COEF_W = COEF_W_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_enable,
  input  logic signed [COEF_W-1:0] Q [8][8],
  output logic signed [COEF_W-1:0] coef,
  output logic                     coef_valid,
  input  logic                     coef_ready,
  output logic [5:0]               coef_idx,
  output logic                     coef_last,
  output logic                     overflow
);

  logic signed [COEF_W-1:0] bank0 [8][8];
  logic signed [COEF_W-1:0] bank1 [8][8];

  logic [1:0]   full;
  logic [1:0]   full_next;
  logic         wr_sel;
  logic         rd_sel;
  logic         rd_sel_next;
  logic [5:0]   rd_ptr;
  logic [5:0]   rd_ptr_next;
  drain_state_t state;
  drain_state_t state_next;

  logic         capture;
  logic         drop;
  logic         release_bank;
  logic         load_beat;
  logic         valid_next;
  logic [2:0]   rom_row;
  logic [2:0]   rom_col;
  logic signed [COEF_W-1:0] beat_coef;

  // Ping-pong banks: wr_sel's bank being full means both are full
  assign capture = in_enable && !full[wr_sel];
  assign drop    = in_enable && (&full);

  zigzag_index_rom u_rom (
    .idx (rd_ptr_next),
    .row (rom_row),
    .col (rom_col)
  );

  // The ROM is addressed with the next beat so the output flops load it directly
  assign beat_coef = rd_sel_next ? bank1[rom_row][rom_col] : bank0[rom_row][rom_col];

  always_comb begin
    state_next   = state;
    rd_ptr_next  = rd_ptr;
    rd_sel_next  = rd_sel;
    valid_next   = coef_valid;
    load_beat    = 1'b0;
    release_bank = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_sel]) begin
          state_next  = SEND;
          rd_ptr_next = '0;
          load_beat   = 1'b1;
          valid_next  = 1'b1;
        end
      end
      SEND: begin
        if (coef_ready) begin
          if (rd_ptr != 6'd63) begin
            rd_ptr_next = rd_ptr + 6'd1;
            load_beat   = 1'b1;
          end else begin
            release_bank = 1'b1;
            rd_sel_next  = ~rd_sel;
            rd_ptr_next  = '0;
            if (full[~rd_sel]) begin
              load_beat = 1'b1;
            end else begin
              state_next = IDLE;
              valid_next = 1'b0;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture only targets a bank that was empty before the edge, so it never
  // collides with the bank being released in the same cycle
  always_comb begin
    full_next = full;
    if (release_bank) full_next[rd_sel] = 1'b0;
    if (capture)      full_next[wr_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_ptr     <= '0;
      rd_sel     <= 1'b0;
      wr_sel     <= 1'b0;
      full       <= '0;
      overflow   <= 1'b0;
      coef       <= '0;
      coef_idx   <= '0;
      coef_last  <= 1'b0;
      coef_valid <= 1'b0;
    end else begin
      state      <= state_next;
      rd_ptr     <= rd_ptr_next;
      rd_sel     <= rd_sel_next;
      full       <= full_next;
      coef_valid <= valid_next;
      if (capture) wr_sel <= ~wr_sel;
      if (drop) overflow <= 1'b1;
      if (load_beat) begin
        coef      <= beat_coef;
        coef_idx  <= rd_ptr_next;
        coef_last <= (rd_ptr_next == 6'd63);
      end
    end
  end

  // Bank contents carry no reset; the full flags alone say what is valid
  always_ff @(posedge clk) begin
    if (capture && !wr_sel) bank0 <= Q;
    if (capture && wr_sel)  bank1 <= Q;
  end

endmodule

// File: tb/tb_cb_zigzag_serializer.sv
// Bench for cb_zigzag_serializer: a block-queue model predicts the zig-zag
// stream, and directed scenarios pin latency, gap-free draining, overflow and reset.
module tb_cb_zigzag_serializer;
  import jpeg_pkg::*;

  localparam int W = COEF_W_DEFAULT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_enable = 1'b0;
  logic coef_ready = 1'b0;
  coef_t q_in [8][8];
  logic signed [W-1:0] coef;
  logic coef_valid;
  logic [5:0] coef_idx;
  logic coef_last;
  logic overflow;

  int n_compared = 0;
  int n_mismatch = 0;

  typedef struct {
    int value;
    int idx;
  } beat_t;

  beat_t exp_q[$];
  int    pending = 0;
  bit    exp_ovf = 1'b0;
  int    idle_run = 0;
  bit    prev_stall = 1'b0;
  int    prev_coef = 0;
  int    prev_idx = 0;
  int    zz_r [64];
  int    zz_c [64];

  cb_zigzag_serializer #(.COEF_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_enable  (in_enable),
    .Q          (q_in),
    .coef       (coef),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_idx   (coef_idx),
    .coef_last  (coef_last),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Zig-zag order derived by walking anti-diagonals, alternating direction
  function automatic void build_zigzag();
    int n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin
          zz_r[n] = r; zz_c[n] = s - r; n++;
        end
      end else begin
        for (int r = lo; r <= hi; r++) begin
          zz_r[n] = r; zz_c[n] = s - r; n++;
        end
      end
    end
  endfunction

  task automatic check_output(input string name, input logic signed [31:0] actual,
                              input logic signed [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // kind 0: 8*r+c+val, kind 1: constant val, kind 2: random signed values
  task automatic apply_stimulus(input int kind, input int val);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        case (kind)
          0:       q_in[r][c] = coef_t'(8 * r + c + val);
          1:       q_in[r][c] = coef_t'(val);
          default: q_in[r][c] = coef_t'($urandom_range(0, 2047));
        endcase
  endtask

  task automatic drain(input string name, input int budget);
    int cnt = 0;
    while ((exp_q.size() > 0 || coef_valid) && cnt < budget) begin
      tick();
      cnt++;
    end
    check_output(name, exp_q.size(), 0);
  endtask

  // Compare on the falling edge, then advance the model for the coming rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pending    = 0;
      exp_ovf    = 1'b0;
      idle_run   = 0;
      prev_stall = 1'b0;
    end else begin
      bit accept;
      check_output("overflow", overflow, exp_ovf);
      if (prev_stall) begin
        check_output("stall_valid", coef_valid, 1);
        check_output("stall_coef", coef, prev_coef);
        check_output("stall_idx", coef_idx, prev_idx);
      end
      if (coef_valid) begin
        idle_run = 0;
        if (exp_q.size() == 0) begin
          check_output("spurious_valid", coef_valid, 0);
        end else begin
          check_output("coef", coef, exp_q[0].value);
          check_output("coef_idx", coef_idx, exp_q[0].idx);
          check_output("coef_last", coef_last, exp_q[0].idx == 63);
        end
      end else if (exp_q.size() > 0) begin
        idle_run++;
        if (idle_run == 2) check_output("stream_bubble", idle_run, 1);
      end else begin
        idle_run = 0;
      end
      prev_stall = coef_valid && !coef_ready;
      prev_coef  = coef;
      prev_idx   = coef_idx;

      accept = in_enable && (pending < 2);
      if (in_enable && !accept) exp_ovf = 1'b1;
      if (coef_valid && coef_ready && exp_q.size() > 0) begin
        if (exp_q[0].idx == 63) pending--;
        void'(exp_q.pop_front());
      end
      if (accept) begin
        pending++;
        for (int k = 0; k < 64; k++) begin
          beat_t b;
          b.value = q_in[zz_r[k]][zz_c[k]];
          b.idx   = k;
          exp_q.push_back(b);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int cnt;
    int gaps;
    int beats;

    build_zigzag();
    check_output("model_zz4_row", zz_r[4], 1);
    check_output("model_zz9_row", zz_r[9], 3);
    check_output("model_zz62_col", zz_c[62], 6);
    apply_stimulus(0, 0);

    repeat (2) @(posedge clk);
    #3;
    check_output("rst_valid", coef_valid, 0);
    check_output("rst_coef", coef, 0);
    check_output("rst_idx", coef_idx, 0);
    check_output("rst_last", coef_last, 0);
    check_output("rst_overflow", overflow, 0);
    tick();
    rst_n = 1'b1;

    // Single 8r+c block with the consumer always ready
    $display("[TB] single block");
    coef_ready = 1'b1;
    in_enable  = 1'b1;
    tick();
    in_enable = 1'b0;
    #1 check_output("latency_t1_valid", coef_valid, 0);
    tick();
    #1 check_output("latency_t2_valid", coef_valid, 1);
    check_output("first_coef", coef, 0);
    check_output("first_idx", coef_idx, 0);
    tick();
    #1 check_output("beat1_coef", coef, 1);
    tick();
    #1 check_output("beat2_coef", coef, 8);
    tick();
    #1 check_output("beat3_coef", coef, 16);
    repeat (60) tick();
    #1 check_output("beat63_idx", coef_idx, 63);
    check_output("beat63_last", coef_last, 1);
    check_output("beat63_coef", coef, 63);
    tick();
    #1 check_output("single_done_valid", coef_valid, 0);

    // Random backpressure with a second block injected mid-stream
    $display("[TB] backpressure");
    apply_stimulus(2, 0);
    in_enable = 1'b1;
    tick();
    in_enable = 1'b0;
    cnt = 0;
    while ((exp_q.size() > 0 || coef_valid) && cnt < 2000) begin
      coef_ready = 1'($urandom_range(0, 1));
      if (cnt == 30) begin
        apply_stimulus(2, 0);
        in_enable = 1'b1;
      end else begin
        in_enable = 1'b0;
      end
      tick();
      cnt++;
    end
    in_enable = 1'b0;
    check_output("bp_drained", exp_q.size(), 0);

    // Two blocks one cycle apart must drain as 128 gap-free beats
    $display("[TB] back-to-back");
    coef_ready = 1'b1;
    apply_stimulus(1, 5);
    in_enable = 1'b1;
    tick();
    apply_stimulus(1, -7);
    tick();
    in_enable = 1'b0;
    #1 check_output("b2b_first_valid", coef_valid, 1);
    check_output("b2b_first_coef", coef, 5);
    gaps = 0;
    for (int k = 1; k < 128; k++) begin
      tick();
      #1;
      if (!coef_valid) gaps++;
      if (k == 63) begin
        check_output("b2b_63_coef", coef, 5);
        check_output("b2b_63_last", coef_last, 1);
      end
      if (k == 64) begin
        check_output("b2b_64_coef", coef, -7);
        check_output("b2b_64_idx", coef_idx, 0);
      end
    end
    check_output("b2b_gaps", gaps, 0);
    tick();
    #1 check_output("b2b_done_valid", coef_valid, 0);

    // Three strobes while stalled: the third is dropped
    $display("[TB] overflow");
    coef_ready = 1'b0;
    apply_stimulus(1, 1);
    in_enable = 1'b1;
    tick();
    apply_stimulus(1, 2);
    tick();
    apply_stimulus(1, 3);
    #1 check_output("ovf_before_third", overflow, 0);
    tick();
    in_enable = 1'b0;
    #1 check_output("ovf_after_third", overflow, 1);
    coef_ready = 1'b1;
    beats = 0;
    cnt = 0;
    while (exp_q.size() > 0 && cnt < 400) begin
      if (coef_valid && coef_ready) beats++;
      tick();
      cnt++;
    end
    check_output("ovf_beats", beats, 128);
    tick();
    #1 check_output("ovf_done_valid", coef_valid, 0);
    check_output("ovf_sticky", overflow, 1);

    // New block strobed in the same cycle as the final beat of the current one
    $display("[TB] release/capture collision");
    apply_stimulus(1, 9);
    in_enable = 1'b1;
    tick();
    in_enable = 1'b0;
    cnt = 0;
    while (!(coef_valid && coef_idx == 6'd63) && cnt < 200) begin
      tick();
      cnt++;
    end
    check_output("coll_reach63", coef_idx, 63);
    apply_stimulus(1, -3);
    in_enable = 1'b1;
    tick();
    in_enable = 1'b0;
    cnt = 0;
    while (!coef_valid && cnt < 5) begin
      tick();
      cnt++;
    end
    #1 check_output("coll_next_valid", coef_valid, 1);
    check_output("coll_next_coef", coef, -3);
    check_output("coll_next_idx", coef_idx, 0);
    drain("coll_drained", 200);

    // Asynchronous reset in the middle of a block
    $display("[TB] reset mid-stream");
    apply_stimulus(2, 0);
    in_enable = 1'b1;
    tick();
    in_enable = 1'b0;
    cnt = 0;
    while (!(coef_valid && coef_idx == 6'd20) && cnt < 200) begin
      tick();
      cnt++;
    end
    check_output("mid_reach20", coef_idx, 20);
    #1 rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid", coef_valid, 0);
    check_output("mid_rst_coef", coef, 0);
    check_output("mid_rst_idx", coef_idx, 0);
    check_output("mid_rst_last", coef_last, 0);
    check_output("mid_rst_overflow", overflow, 0);
    tick();
    tick();
    rst_n = 1'b1;
    apply_stimulus(0, -30);
    in_enable = 1'b1;
    tick();
    in_enable = 1'b0;
    tick();
    #1 check_output("post_rst_valid", coef_valid, 1);
    check_output("post_rst_coef", coef, -30);
    check_output("post_rst_idx", coef_idx, 0);
    drain("post_rst_drained", 200);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
